// File: rtl/axis_pkt_pkg.sv
// Shared types and helpers for the AXI4-Stream packet source.
package axis_pkt_pkg;

    localparam int MAX_LEN_W = 32;

    typedef struct packed {
        logic [MAX_LEN_W-1:0] len;
        logic [7:0]           seed;
    } cmd_t;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // r = valid bytes in the final beat modulo db; r == 0 means a full beat
    function automatic logic [7:0] keep_mask(input logic [3:0] r,
                                             input logic [3:0] db);
        logic [3:0] n;
        logic [7:0] m;
        n = (r == 4'd0) ? db : r;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_pkt_cmd_fifo.sv
// Command FIFO for the packet source: power-of-2 depth, full/empty flags.
module axis_pkt_cmd_fifo
    import axis_pkt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  cmd_t data_i,
    input  logic pop_i,
    output cmd_t head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    cmd_t        mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/axis_pkt_src.sv
// AXI4-Stream packet source: queued commands become packets of
// incrementing bytes, with tkeep trimming the final beat.
module axis_pkt_src
    import axis_pkt_pkg::*;
#(
    parameter int DATA_BYTES = 1,
    parameter int LEN_WIDTH  = 16,
    parameter int CMD_DEPTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic [7:0]              cmd_seed,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [8*DATA_BYTES-1:0] m_axis_tdata,
    output logic [DATA_BYTES-1:0]   m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    busy,
    output logic                    pkt_done,
    output logic [CNT_WIDTH-1:0]    pkt_cnt
);

    state_t                  state_q, state_d;
    logic                    tvalid_q, tvalid_d;
    logic [8*DATA_BYTES-1:0] tdata_q;
    logic [DATA_BYTES-1:0]   tkeep_q;
    logic                    tlast_q;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;
    logic [7:0]              nxt_q, nxt_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    done_q, done_d;

    cmd_t                    cmd_in;
    cmd_t                    head;
    logic                    full;
    logic                    empty;
    logic                    pop;
    logic                    load;
    logic                    ld_new;
    logic                    head_nz;
    logic [LEN_WIDTH-1:0]    src_n;
    logic [7:0]              src_s;
    logic [3:0]              nb;
    logic [8*DATA_BYTES-1:0] beat_data;
    logic [DATA_BYTES-1:0]   beat_keep;
    logic                    beat_last;

    assign cmd_in.len  = MAX_LEN_W'(cmd_len);
    assign cmd_in.seed = cmd_seed;
    assign head_nz     = |head.len;

    axis_pkt_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk_i   (aclk),
        .rst_i   (areset),
        .push_i  (cmd_valid),
        .data_i  (cmd_in),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d  = state_q;
        tvalid_d = tvalid_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        pop      = 1'b0;
        load     = 1'b0;
        ld_new   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_nz) begin
                        load     = 1'b1;
                        ld_new   = 1'b1;
                        tvalid_d = 1'b1;
                        state_d  = SEND;
                    end
                end
            end
            SEND: begin
                if (m_axis_tready) begin
                    if (!tlast_q) begin
                        load = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        cnt_d  = cnt_q + CNT_WIDTH'(1);
                        // chain the next packet on the same edge
                        if (!empty && head_nz) begin
                            pop    = 1'b1;
                            load   = 1'b1;
                            ld_new = 1'b1;
                        end else begin
                            tvalid_d = 1'b0;
                            state_d  = IDLE;
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        src_n = ld_new ? head.len[LEN_WIDTH-1:0] : rem_q;
        src_s = ld_new ? head.seed : nxt_q;
        if (src_n >= LEN_WIDTH'(DATA_BYTES)) nb = 4'(DATA_BYTES);
        else                                 nb = src_n[3:0];
        rem_d     = src_n - LEN_WIDTH'(nb);
        nxt_d     = src_s + {4'd0, nb};
        beat_last = (rem_d == '0);
        beat_keep = DATA_BYTES'(keep_mask(nb & 4'(DATA_BYTES - 1),
                                          4'(DATA_BYTES)));
        beat_data = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (i < int'(nb)) beat_data[i*8 +: 8] = src_s + 8'(i);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= IDLE;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            rem_q    <= '0;
            nxt_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tvalid_q <= tvalid_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            if (load) begin
                tdata_q <= beat_data;
                tkeep_q <= beat_keep;
                tlast_q <= beat_last;
                rem_q   <= rem_d;
                nxt_q   <= nxt_d;
            end
        end
    end

    assign cmd_ready     = !full;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = (state_q == SEND) || !empty;
    assign pkt_done      = done_q;
    assign pkt_cnt       = cnt_q;

endmodule

// File: doc/axis_pkt_src.md
Name: axis_pkt_src

Overview:
Parametrised AXI4-Stream packet source for testbench and loopback use, replacing the fixed 8-bit master endpoint.
- Accepts packet commands (byte length, seed) through a valid/ready command port into a small FIFO.
- Emits each command as an AXI4-Stream packet of incrementing byte data, with tkeep on the final beat and tlast.
- Sits between a test sequencer or register block and any AXI4-Stream slave under test.

Parameters:
DATA_BYTES, 1, tdata width in bytes (tdata = 8*DATA_BYTES bits); allowed values 1, 2, 4, 8
LEN_WIDTH, 16, width of the packet length field, in bytes
CMD_DEPTH, 4, command FIFO depth; power of 2, at least 2
CNT_WIDTH, 16, width of the completed-packet counter

Ports:
aclk  in  1  clock; all logic on the rising edge
areset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command FIFO not full
cmd_len  in  LEN_WIDTH  packet length in bytes
cmd_seed  in  8  value of the first byte of the packet
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tdata  out  8*DATA_BYTES  stream data; byte 0 in the LSBs
m_axis_tkeep  out  DATA_BYTES  byte qualifiers
m_axis_tlast  out  1  last beat of packet
busy  out  1  a packet is in flight or the FIFO is non-empty
pkt_done  out  1  one-cycle pulse on the tlast handshake
pkt_cnt  out  CNT_WIDTH  completed packets, wraps modulo 2^CNT_WIDTH

Behaviour:
Reset (async assert, sync release):
- All outputs go to 0 except cmd_ready, which is 1 after reset.
- FIFO is flushed; FSM returns to IDLE.
- Reset mid-packet drops tvalid immediately. The partial packet is abandoned and is not resumed.

Command port:
- A command is pushed when cmd_valid && cmd_ready.
- cmd_ready = !full. There is no bypass: when full, cmd_ready stays 0 even if a pop happens in the same cycle.
- Simultaneous push and pop on a non-full FIFO keeps the occupancy unchanged.

FSM states: IDLE, SEND.
- IDLE: if the FIFO is non-empty, pop a command.
  - len == 0: discard it, stay in IDLE, no pkt_done, no count.
  - otherwise: load beat 0 into the output register, set tvalid = 1, go to SEND.
- SEND: hold tdata/tkeep/tlast/tvalid stable while tvalid && !tready (AXI rule).
- On a handshake of a non-last beat: load the next beat.
- On a handshake of the last beat:
  - pulse pkt_done and increment pkt_cnt;
  - if the FIFO is non-empty and the next command has len != 0, pop it and load its beat 0 on the same edge (no bubble);
  - otherwise set tvalid = 0 and go to IDLE.

Latency:
- A command handshaken in cycle n into an empty, idle block gives tvalid = 1 in cycle n+2.
- Throughput is one beat per cycle when tready is held high.

Data rules:
- Byte k of the packet (k = 0 .. len-1) equals (seed + k) mod 256.
- Beat b carries bytes b*DATA_BYTES .. b*DATA_BYTES + DATA_BYTES-1.
- Beat count = ceil(len / DATA_BYTES).
- Non-last beats: tkeep all ones.
- Last beat: tkeep = low r bits set, where r = len mod DATA_BYTES, or all ones if r == 0. Bytes with tkeep = 0 are driven as 0x00.
- The remaining-byte counter is LEN_WIDTH bits. The maximum length 2^LEN_WIDTH-1 must be handled without overflow.

busy = (state == SEND) || !empty.

Decomposition:
- Package axis_pkt_pkg:
  - cmd_t struct {len, seed};
  - state_t enum {IDLE, SEND};
  - function keep_mask(r) returning the tkeep vector.
- One sub-module, axis_pkt_cmd_fifo: synchronous FIFO of cmd_t, depth CMD_DEPTH, with full/empty flags, async active-high reset.
- The FSM, beat generation and output register stay in the top module.

Test Plan:
- DATA_BYTES=4, cmd len=10 seed=0x10, tready=1 -> 3 beats: 0x13121110 keep 0xF; 0x17161514 keep 0xF; 0x00001918 keep 0x3 tlast=1; pkt_done pulse; pkt_cnt=1; tvalid first high 2 cycles after the command handshake.
- DATA_BYTES=1, len=3 seed=0xFE -> bytes 0xFE, 0xFF, 0x00 (wrap); tlast on the third beat.
- Back-to-back: 4 commands len=8 with DATA_BYTES=4, tready=1 -> 8 consecutive beats with no bubble; a 5th command pushed while full sees cmd_ready=0; pkt_cnt=4.
- Backpressure: random tready with 30% high -> tdata/tkeep/tlast stable while tvalid && !tready; the byte sequence matches the scoreboard.
- len=0 command followed by len=1 seed=0xAA -> exactly one beat, data 0xAA, tkeep 0x1, tlast=1; pkt_cnt increments by 1 only.
- areset asserted mid-packet (beat 1 of 3) -> tvalid=0 asynchronously, busy=0, pkt_cnt=0, cmd_ready=1 after release; a new command then produces a clean packet from beat 0.
